// File: rtl/cd_rx_drain.sv
// RX drain engine: pulls a pending RX page out of cd_csr and streams it on a valid/ready port.
// Shares the CSR port with a host master (host wins collisions) and shadows clear-on-read INT_FLAG bits.
`timescale 1ns/1ps
module cd_rx_drain (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        rx_pending,
  input  logic [3:0]  h_address,
  input  logic        h_read,
  input  logic        h_write,
  input  logic [31:0] h_writedata,
  output logic [31:0] h_readdata,
  output logic        h_waitrequest,
  output logic [3:0]  csr_address,
  output logic        csr_read,
  output logic        csr_write,
  output logic [31:0] csr_writedata,
  input  logic [31:0] csr_readdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic [7:0]  out_len,
  output logic        busy,
  output logic [15:0] frames
);

  localparam logic [3:0] A_INT_FLAG  = 4'ha;
  localparam logic [3:0] A_RX        = 4'hb;
  localparam logic [3:0] A_RX_CTRL   = 4'hd;
  localparam logic [7:0] SHADOW_MASK = 8'hdc;

  typedef enum logic [2:0] {IDLE, RD_FLAG, RST_PTR, RD_WORD, DONE, COOL} state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        cool_q, cool_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [15:0] frames_q, frames_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;
  logic [7:0]  out_len_q, out_len_d;

  logic        host_req, host_hold, host_gnt, host_int_rd;
  logic        eng_rd, eng_wr;
  logic [3:0]  eng_addr;
  logic [31:0] eng_wdata;
  logic [8:0]  nwords;

  assign nwords = ({1'b0, len_q} + 9'd3) >> 2;

  // RX and RX_CTRL belong to the engine from the pointer reset until the release write completes.
  assign host_req      = h_read | h_write;
  assign host_hold     = (state_q == RST_PTR || state_q == RD_WORD || state_q == DONE) &&
                         (h_address == A_RX || h_address == A_RX_CTRL);
  assign h_waitrequest = host_req & host_hold;
  assign host_gnt      = host_req & ~host_hold;
  assign host_int_rd   = host_gnt & h_read & (h_address == A_INT_FLAG);

  assign csr_address   = host_gnt ? h_address   : eng_addr;
  assign csr_read      = host_gnt ? h_read      : eng_rd;
  assign csr_write     = host_gnt ? h_write     : eng_wr;
  assign csr_writedata = host_gnt ? h_writedata : eng_wdata;
  assign h_readdata    = csr_readdata | (host_int_rd ? {24'h0, shadow_q} : 32'h0);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    cool_d      = cool_q;
    shadow_d    = shadow_q;
    frames_d    = frames_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    out_len_d   = out_len_q;
    eng_rd      = 1'b0;
    eng_wr      = 1'b0;
    eng_addr    = 4'h0;
    eng_wdata   = 32'h0;

    if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
    end
    if (host_int_rd) shadow_d = 8'h00;

    case (state_q)
      IDLE: if (enable & rx_pending & ~out_valid_q) state_d = RD_FLAG;
      RD_FLAG: begin
        eng_rd   = 1'b1;
        eng_addr = A_INT_FLAG;
        if (!host_gnt) begin
          len_d    = csr_readdata[15:8];
          shadow_d = shadow_q | (csr_readdata[7:0] & SHADOW_MASK);
          state_d  = (csr_readdata[15:8] == 8'h00) ? DONE : RST_PTR;
        end
      end
      RST_PTR: begin
        eng_wr   = 1'b1;
        eng_addr = A_RX_CTRL;
        if (!host_gnt) begin
          cnt_d   = 9'd0;
          state_d = RD_WORD;
        end
      end
      RD_WORD: begin
        // Only fetch when the output slot is free or being emptied this cycle.
        eng_rd   = ~out_valid_q | out_ready;
        eng_addr = A_RX;
        if (eng_rd && !host_gnt) begin
          out_valid_d = 1'b1;
          out_data_d  = csr_readdata;
          out_sof_d   = (cnt_q == 9'd0);
          out_eof_d   = (cnt_q + 9'd1 == nwords);
          out_len_d   = len_q;
          cnt_d       = cnt_q + 9'd1;
          if (cnt_q + 9'd1 == nwords) state_d = DONE;
        end
      end
      DONE: begin
        eng_wr    = 1'b1;
        eng_addr  = A_RX_CTRL;
        eng_wdata = 32'h2;
        if (!host_gnt) begin
          if (len_q != 8'h00) frames_d = frames_q + 16'd1;
          cool_d  = 1'b0;
          state_d = COOL;
        end
      end
      COOL: begin
        if (cool_q) state_d = IDLE;
        else        cool_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      len_q       <= 8'h00;
      cnt_q       <= 9'd0;
      cool_q      <= 1'b0;
      shadow_q    <= 8'h00;
      frames_q    <= 16'h0000;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_len_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      cool_q      <= cool_d;
      shadow_q    <= shadow_d;
      frames_q    <= frames_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_len_q   <= out_len_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign out_len   = out_len_q;
  assign busy      = (state_q != IDLE);
  assign frames    = frames_q;

endmodule

// File: tb/tb_cd_rx_drain.sv
// Bench for cd_rx_drain: behavioural cd_csr model, table-driven frames, hand corner cases, random frames.
`timescale 1ns/1ps
module tb_cd_rx_drain;

  logic        clk = 1'b0;
  logic        reset_n, enable, rx_pending;
  logic [3:0]  h_address;
  logic        h_read, h_write;
  logic [31:0] h_writedata, h_readdata;
  logic        h_waitrequest;
  logic [3:0]  csr_address;
  logic        csr_read, csr_write;
  logic [31:0] csr_writedata, csr_readdata;
  logic        out_valid, out_ready, out_sof, out_eof, busy;
  logic [31:0] out_data;
  logic [7:0]  out_len;
  logic [15:0] frames;

  always #5 clk = ~clk;

  cd_rx_drain dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rx_pending(rx_pending),
    .h_address(h_address), .h_read(h_read), .h_write(h_write), .h_writedata(h_writedata),
    .h_readdata(h_readdata), .h_waitrequest(h_waitrequest),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .out_len(out_len),
    .busy(busy), .frames(frames)
  );

  // cd_csr model: VERSION at 0x0, INT_FLAG {len, clear-on-read flags}, RX RAM behind an auto-incrementing pointer.
  logic [31:0] rx_mem [64];
  logic [7:0]  m_len, m_flags;
  logic        m_pend;
  logic [5:0]  m_ptr;
  logic        p_clr_flags, p_ptr_inc, p_ptr_zero, p_done;

  assign rx_pending = m_pend;

  always_comb begin
    csr_readdata = 32'h0;
    case (csr_address)
      4'h0:    csr_readdata = 32'h0000_000f;
      4'ha:    csr_readdata = {16'h0, m_len, m_flags};
      4'hb:    csr_readdata = rx_mem[m_ptr];
      default: csr_readdata = 32'h0;
    endcase
  end

  typedef struct { logic [31:0] d; logic sof; logic eof; logic [7:0] len; } word_t;
  typedef struct { logic wr; logic [3:0] a; logic [31:0] d; } txn_t;
  typedef struct { int len; int rdy; int words; int txns; int busyc; } vec_t;

  word_t exp_q[$];
  txn_t  log_q[$];
  vec_t  tbl[8];
  int vectors = 0, miscompares = 0;
  int exp_frames = 0, busy_cyc = 0, got_words = 0, rx_reads = 0, sh_exp = 0;
  int rdy_mode = 0, host_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick_a();
    word_t e;
    @(negedge clk);
    p_clr_flags = 1'b0; p_ptr_inc = 1'b0; p_ptr_zero = 1'b0; p_done = 1'b0;
    if (csr_read && csr_address == 4'ha) p_clr_flags = 1'b1;
    if (csr_read && csr_address == 4'hb) begin p_ptr_inc = 1'b1; rx_reads++; end
    if (csr_write && csr_address == 4'hd) begin
      if (csr_writedata == 32'h0) p_ptr_zero = 1'b1;
      if (csr_writedata == 32'h2) p_done = 1'b1;
    end
    if ((csr_read || csr_write) && csr_address inside {4'ha, 4'hb, 4'hd})
      log_q.push_back('{csr_write, csr_address, csr_writedata});
    if (busy) busy_cyc++;
    if (host_mode == 1 && h_read && !h_waitrequest) chk("host_version", h_readdata, 32'h0f);
    if (out_valid && out_ready) begin
      got_words++;
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL extra_word: got 0x%0h, expected no word", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", out_data, e.d);
        chk("word_sof", 32'(out_sof), 32'(e.sof));
        chk("word_eof", 32'(out_eof), 32'(e.eof));
        if (e.sof) chk("word_len", 32'(out_len), 32'(e.len));
      end
    end
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
    if (p_clr_flags) m_flags = 8'h00;
    if (p_ptr_zero) m_ptr = 6'd0;
    else if (p_ptr_inc) m_ptr = m_ptr + 6'd1;
    if (p_done) m_pend = 1'b0;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    if (host_mode == 1) begin
      h_read    = ($urandom_range(0, 3) == 0);
      h_address = 4'h0;
    end
  endtask

  task automatic tick();
    tick_a();
    tick_b();
  endtask

  task automatic load_frame(input int len, input int flags);
    int n;
    for (int i = 0; i < 64; i++) rx_mem[i] = $urandom;
    m_len   = 8'(len);
    m_flags = m_flags | 8'(flags);
    m_pend  = 1'b1;
    n = (len + 3) / 4;
    for (int i = 0; i < n; i++) exp_q.push_back('{rx_mem[i], i == 0, i == n - 1, 8'(len)});
    log_q.delete();
    busy_cyc = 0; got_words = 0; rx_reads = 0;
    if (len != 0) exp_frames++;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (c < budget && (m_pend || busy || out_valid)) begin
      tick();
      c++;
    end
    if (m_pend || busy || out_valid) begin
      vectors++; miscompares++;
      $display("FAIL frame_timeout: still busy after %0d cycles, expected idle", budget);
    end
  endtask

  task automatic wait_rx_read(input string nm);
    int c = 0;
    bit seen = 0;
    while (c < 200 && !seen) begin
      tick_a();
      seen = csr_read && csr_address == 4'hb;
      tick_b();
      c++;
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL %s: no RX read within 200 cycles, expected one", nm);
    end
  endtask

  task automatic wait_words(input int n, input string nm);
    int c = 0;
    while (c < 400 && got_words < n) begin
      tick();
      c++;
    end
    if (got_words < n) begin
      vectors++; miscompares++;
      $display("FAIL %s: got %0d words, expected %0d", nm, got_words, n);
    end
  endtask

  initial begin
    logic [31:0] held;
    int rd0, n, len, flags;

    reset_n = 1'b0; enable = 1'b0; h_address = 4'h0; h_read = 1'b0; h_write = 1'b0;
    h_writedata = 32'h0; out_ready = 1'b1; m_len = 8'h0; m_flags = 8'h0; m_pend = 1'b0; m_ptr = 6'd0;
    p_clr_flags = 1'b0; p_ptr_inc = 1'b0; p_ptr_zero = 1'b0; p_done = 1'b0;
    for (int i = 0; i < 64; i++) rx_mem[i] = 32'h0;

    tbl[0] = '{9,   0, 3,  6,  8};
    tbl[1] = '{0,   0, 0,  2,  4};
    tbl[2] = '{255, 0, 64, 67, 69};
    tbl[3] = '{16,  1, 4,  7,  0};
    tbl[4] = '{1,   0, 1,  4,  6};
    tbl[5] = '{4,   1, 1,  4,  0};
    tbl[6] = '{5,   0, 2,  5,  7};
    tbl[7] = '{252, 1, 63, 66, 0};

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frames", 32'(frames), 32'h0);
    chk("rst_csr_strobes", 32'({csr_read, csr_write}), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_sof_eof_len", 32'({out_sof, out_eof, out_len}), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    enable = 1'b1;

    for (int v = 0; v < 8; v++) begin
      rdy_mode = tbl[v].rdy;
      load_frame(tbl[v].len, 0);
      wait_done(600);
      chk("tbl_words", 32'(got_words), 32'(tbl[v].words));
      chk("tbl_rx_reads", 32'(rx_reads), 32'(tbl[v].words));
      chk("tbl_words_left", 32'(exp_q.size()), 32'h0);
      chk("tbl_frames", 32'(frames), 32'(exp_frames));
      chk("tbl_txn_count", 32'(log_q.size()), 32'(tbl[v].txns));
      if (log_q.size() >= 2) begin
        chk("tbl_first_txn", 32'({log_q[0].wr, log_q[0].a}), 32'h0a);
        chk("tbl_last_txn", 32'({log_q[$].wr, log_q[$].a}), 32'h1d);
        chk("tbl_last_data", log_q[$].d, 32'h2);
        if (tbl[v].len != 0) begin
          chk("tbl_rst_ptr", 32'({log_q[1].wr, log_q[1].a}), 32'h1d);
          chk("tbl_rst_data", log_q[1].d, 32'h0);
        end
      end
      if (tbl[v].rdy == 0) chk("tbl_busy_cycles", 32'(busy_cyc), 32'(tbl[v].busyc));
    end

    // Consumer stall after word 2: the held word must not change and no RX read may be issued.
    rdy_mode = 2; out_ready = 1'b1;
    load_frame(16, 0);
    wait_words(2, "stall_lead");
    out_ready = 1'b0;
    rd0 = rx_reads;
    tick_a();
    held = out_data;
    chk("stall_valid", 32'(out_valid), 32'h1);
    tick_b();
    for (int i = 0; i < 4; i++) begin
      tick_a();
      chk("stall_hold", out_data, held);
      tick_b();
    end
    chk("stall_no_read", 32'(rx_reads), 32'(rd0));
    rdy_mode = 0; out_ready = 1'b1;
    wait_done(200);
    chk("stall_words", 32'(got_words), 32'h4);
    chk("stall_words_left", 32'(exp_q.size()), 32'h0);

    // Host VERSION read collides with an engine RX read.
    load_frame(16, 0);
    wait_rx_read("coll_lead");
    h_read = 1'b1; h_address = 4'h0;
    tick_a();
    chk("coll_host_data", h_readdata, 32'h0f);
    chk("coll_host_wait", 32'(h_waitrequest), 32'h0);
    chk("coll_bus_addr", 32'(csr_address), 32'h0);
    tick_b();
    h_read = 1'b0;
    tick_a();
    chk("coll_engine_repeat", 32'({csr_read, csr_address}), 32'h1b);
    tick_b();
    wait_done(200);
    chk("coll_words_left", 32'(exp_q.size()), 32'h0);
    chk("coll_rx_reads", 32'(rx_reads), 32'h4);
    chk("coll_frames", 32'(frames), 32'(exp_frames));

    // Host RX read mid-frame stalls until the release write has gone out.
    rdy_mode = 1;
    load_frame(32, 0);
    wait_rx_read("hostrx_lead");
    h_read = 1'b1; h_address = 4'hb;
    begin
      int c = 0;
      bit first = 1;
      bit released = 0;
      while (c < 400 && !released) begin
        tick_a();
        if (first) chk("hostrx_wait", 32'(h_waitrequest), 32'h1);
        first = 0;
        if (!h_waitrequest) begin
          released = 1;
          chk("hostrx_after_done", 32'(m_pend), 32'h0);
          chk("hostrx_passthru", 32'({csr_read, csr_address}), 32'h1b);
        end
        tick_b();
        c++;
      end
      if (!released) begin
        vectors++; miscompares++;
        $display("FAIL hostrx_release: waitrequest still high after %0d cycles, expected low", c);
      end
    end
    h_read = 1'b0;
    wait_done(400);
    chk("hostrx_words_left", 32'(exp_q.size()), 32'h0);
    chk("hostrx_words", 32'(got_words), 32'h8);

    // rx_lost (bit 3) consumed by the engine must still reach the host once.
    rdy_mode = 0;
    load_frame(4, 8'h09);
    wait_done(200);
    h_read = 1'b1; h_address = 4'ha;
    tick_a();
    chk("shadow_bit3", 32'(h_readdata[3]), 32'h1);
    chk("shadow_bit0", 32'(h_readdata[0]), 32'h0);
    chk("intflag_len", 32'(h_readdata[15:8]), 32'h4);
    tick_b();
    tick_a();
    chk("shadow_cleared", 32'(h_readdata[3]), 32'h0);
    tick_b();
    h_read = 1'b0;

    // Asynchronous reset in the middle of a drain, then a full restart of the same page.
    load_frame(32, 0);
    wait_words(3, "rst_lead");
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_frames", 32'(frames), 32'h0);
    chk("mid_rst_strobes", 32'({csr_read, csr_write}), 32'h0);
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_pending", 32'(rx_pending), 32'h1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back('{rx_mem[i], i == 0, i == 7, 8'd32});
    got_words = 0;
    exp_frames = 1;
    wait_done(200);
    chk("rst_restart_words", 32'(got_words), 32'h8);
    chk("rst_restart_left", 32'(exp_q.size()), 32'h0);
    chk("rst_restart_frames", 32'(frames), 32'h1);

    // Random frames with random backpressure and host VERSION traffic.
    rdy_mode = 1; host_mode = 1;
    for (int f = 0; f < 25; f++) begin
      len   = int'($urandom_range(0, 255));
      flags = int'($urandom_range(0, 255));
      sh_exp = sh_exp | (flags & 'hdc);
      n = (len + 3) / 4;
      load_frame(len, flags);
      wait_done(1500);
      chk("rnd_words", 32'(got_words), 32'(n));
      chk("rnd_rx_reads", 32'(rx_reads), 32'(n));
      chk("rnd_words_left", 32'(exp_q.size()), 32'h0);
      chk("rnd_frames", 32'(frames), 32'(exp_frames & 'hffff));
    end
    host_mode = 0; h_read = 1'b0; rdy_mode = 0;
    tick();
    h_read = 1'b1; h_address = 4'ha;
    tick_a();
    chk("shadow_accum", 32'(h_readdata[7:0]), 32'(sh_exp));
    tick_b();
    h_read = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
